// File: rtl/instr_decode_seq_if.sv
// Program-memory fetch bus for instr_decode_seq.
// master: the sequencer (drives PC/InstrReq); slave: the program memory.
interface instr_decode_seq_if #(
  parameter int unsigned PC_W = 8
);
  logic [PC_W-1:0] PC;
  logic            InstrReq;
  logic            InstrValid;
  logic [7:0]      Instr;

  modport master (output PC, output InstrReq, input InstrValid, input Instr);
  modport slave  (input PC, input InstrReq, output InstrValid, output Instr);
endinterface

// File: rtl/instr_decode_seq.sv
// Fetch/decode sequencer for the 8-bit uProcessor.
// Fetches one- or two-byte instructions over the request/valid bus, latches
// them, and issues a one-cycle EXEC pulse carrying register-file, accumulator
// and ALU controls. Owns the program counter.
// Optional build macro IDSEQ_ILLEGAL_TRAP_EN: adds a Trap output; opcodes
// 0xB-0xE then halt the core with Trap set instead of executing as NOP.
module instr_decode_seq #(
  parameter int unsigned PC_W = 8
) (
  input  logic                clk,
  input  logic                nReset,
  instr_decode_seq_if.master  bus,
  input  logic                ZeroFlag,
  output logic [3:0]          RegNum,
  output logic                RegCE,
  output logic                AccCE,
  output logic [1:0]          AccSrc,
  output logic [2:0]          AluOp,
  output logic [7:0]          Imm,
  output logic                Halted
`ifdef IDSEQ_ILLEGAL_TRAP_EN
  ,
  output logic                Trap
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    IMM   = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  // IR[3:2] carries no information, so only opcode and register index are kept.
  logic [3:0]      opc, opc_n;
  logic [1:0]      rix, rix_n;
  logic [7:0]      imm, imm_n;
  logic [PC_W-1:0] imm_pc;
  logic            req;
`ifdef IDSEQ_ILLEGAL_TRAP_EN
  logic            trap, trap_n;
`endif

  // Cast zero-extends for wide PCs and truncates to the LSBs for narrow ones.
  assign imm_pc = PC_W'(imm);

  // State, PC, instruction and immediate registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state <= FETCH;
      pc    <= '0;
      opc   <= '0;
      rix   <= '0;
      imm   <= '0;
`ifdef IDSEQ_ILLEGAL_TRAP_EN
      trap  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      pc    <= pc_n;
      opc   <= opc_n;
      rix   <= rix_n;
      imm   <= imm_n;
`ifdef IDSEQ_ILLEGAL_TRAP_EN
      trap  <= trap_n;
`endif
    end
  end

  // Next-state, fetch handshake and EXEC-cycle decode.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    opc_n   = opc;
    rix_n   = rix;
    imm_n   = imm;
`ifdef IDSEQ_ILLEGAL_TRAP_EN
    trap_n  = trap;
`endif
    req     = 1'b0;
    RegNum  = '0;
    RegCE   = 1'b0;
    AccCE   = 1'b0;
    AccSrc  = 2'b00;
    AluOp   = 3'd0;

    case (state)
      FETCH: begin
        req = 1'b1;
        if (bus.InstrValid) begin
          opc_n = bus.Instr[7:4];
          rix_n = bus.Instr[1:0];
          pc_n  = pc + PC_W'(1);
          if (bus.Instr[7:4] == 4'h8 || bus.Instr[7:4] == 4'h9 ||
              bus.Instr[7:4] == 4'hA)
            state_n = IMM;
          else
            state_n = EXEC;
        end
      end
      IMM: begin
        req = 1'b1;
        if (bus.InstrValid) begin
          imm_n   = bus.Instr;
          pc_n    = pc + PC_W'(1);
          state_n = EXEC;
        end
      end
      EXEC: begin
        state_n = FETCH;
        if (opc >= 4'h1 && opc <= 4'h7)
          RegNum = 4'b0001 << rix;
        case (opc)
          4'h1: RegCE = 1'b1;
          4'h2: begin
            AccCE  = 1'b1;
            AccSrc = 2'b01;
          end
          4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
            AccCE  = 1'b1;
            AccSrc = 2'b00;
            AluOp  = 3'(opc - 4'd3);
          end
          4'h8: begin
            AccCE  = 1'b1;
            AccSrc = 2'b10;
          end
          4'h9: pc_n = imm_pc;
          4'hA: if (ZeroFlag) pc_n = imm_pc;
          4'hF: state_n = HALT;
          4'hB, 4'hC, 4'hD, 4'hE: begin
`ifdef IDSEQ_ILLEGAL_TRAP_EN
            trap_n  = 1'b1;
            state_n = HALT;
`else
            state_n = FETCH;
`endif
          end
          default: ;
        endcase
      end
      HALT: ;
      default: state_n = FETCH;
    endcase
  end

  assign bus.PC       = pc;
  assign bus.InstrReq = req;
  assign Imm          = imm;
  assign Halted       = (state == HALT);
`ifdef IDSEQ_ILLEGAL_TRAP_EN
  assign Trap         = trap;
`endif

endmodule

// File: tb/tb_instr_decode_seq.sv
// Scoreboard bench for instr_decode_seq: directed program bytes, hand-computed
// per-cycle expectations queued by the stimulus and checked by a monitor.
// A PC_W=4 copy runs the same stimulus; its PC must equal the low nibble.
module tb_instr_decode_seq;

  logic clk = 1'b0;
  logic nReset;
  logic ZeroFlag;
  logic [3:0] RegNum, RegNum4;
  logic RegCE, AccCE, RegCE4, AccCE4, Halted, Halted4;
  logic [1:0] AccSrc, AccSrc4;
  logic [2:0] AluOp, AluOp4;
  logic [7:0] Imm, Imm4;
  logic Trap, Trap4;

  instr_decode_seq_if #(.PC_W(8)) bus8 ();
  instr_decode_seq_if #(.PC_W(4)) bus4 ();

  instr_decode_seq #(.PC_W(8)) dut (
    .clk(clk), .nReset(nReset), .bus(bus8), .ZeroFlag(ZeroFlag),
    .RegNum(RegNum), .RegCE(RegCE), .AccCE(AccCE), .AccSrc(AccSrc),
    .AluOp(AluOp), .Imm(Imm), .Halted(Halted)
`ifdef IDSEQ_ILLEGAL_TRAP_EN
    , .Trap(Trap)
`endif
  );

  instr_decode_seq #(.PC_W(4)) dut4 (
    .clk(clk), .nReset(nReset), .bus(bus4), .ZeroFlag(ZeroFlag),
    .RegNum(RegNum4), .RegCE(RegCE4), .AccCE(AccCE4), .AccSrc(AccSrc4),
    .AluOp(AluOp4), .Imm(Imm4), .Halted(Halted4)
`ifdef IDSEQ_ILLEGAL_TRAP_EN
    , .Trap(Trap4)
`endif
  );

`ifndef IDSEQ_ILLEGAL_TRAP_EN
  assign Trap  = 1'b0;
  assign Trap4 = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] pc;
    logic       req;
    logic [3:0] rn;
    logic       rce;
    logic       ace;
    logic [1:0] src;
    logic [2:0] op;
    logic [7:0] imm;
    logic       halt;
    logic       trap;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, req_v);
    end
  endtask

  // Monitor: compare whenever the queued expectation belongs to this cycle.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("pc",      16'(bus8.PC),       16'(e.pc));
      chk("req",     16'(bus8.InstrReq), 16'(e.req));
      chk("regnum",  16'(RegNum),        16'(e.rn));
      chk("regce",   16'(RegCE),         16'(e.rce));
      chk("acce",    16'(AccCE),         16'(e.ace));
      chk("accsrc",  16'(AccSrc),        16'(e.src));
      chk("aluop",   16'(AluOp),         16'(e.op));
      chk("imm",     16'(Imm),           16'(e.imm));
      chk("halted",  16'(Halted),        16'(e.halt));
      chk("pc4",     16'(bus4.PC),       16'(e.pc[3:0]));
      chk("req4",    16'(bus4.InstrReq), 16'(e.req));
      chk("acce4",   16'(AccCE4),        16'(e.ace));
      chk("halted4", 16'(Halted4),       16'(e.halt));
`ifdef IDSEQ_ILLEGAL_TRAP_EN
      chk("trap",    16'(Trap),          16'(e.trap));
      chk("trap4",   16'(Trap4),         16'(e.trap));
`endif
    end
  end

  task automatic drv(input logic n, input logic v, input logic [7:0] ins, input logic z);
    nReset          = n;
    ZeroFlag        = z;
    bus8.InstrValid = v;
    bus8.Instr      = ins;
    bus4.InstrValid = v;
    bus4.Instr      = ins;
  endtask

  task automatic push(input logic [7:0] pc, input logic req, input logic [3:0] rn,
                      input logic rce, input logic ace, input logic [1:0] src,
                      input logic [2:0] op, input logic [7:0] imm,
                      input logic halt, input logic trap);
    exp_t x;
    x.cyc = cyc; x.pc = pc; x.req = req; x.rn = rn; x.rce = rce; x.ace = ace;
    x.src = src; x.op = op; x.imm = imm; x.halt = halt; x.trap = trap;
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FETCH or IMM cycle: request up, controls idle.
  task automatic F(input logic v, input logic [7:0] ins, input logic [7:0] pc, input logic [7:0] imm);
    drv(1'b1, v, ins, 1'b0);
    push(pc, 1'b1, 4'b0000, 1'b0, 1'b0, 2'b00, 3'd0, imm, 1'b0, 1'b0);
    tick();
  endtask

  // EXEC cycle: bus driven with a junk valid byte that must be ignored.
  task automatic E(input logic z, input logic [7:0] pc, input logic [3:0] rn,
                   input logic rce, input logic ace, input logic [1:0] src,
                   input logic [2:0] op, input logic [7:0] imm);
    drv(1'b1, 1'b1, 8'hF0, z);
    push(pc, 1'b0, rn, rce, ace, src, op, imm, 1'b0, 1'b0);
    tick();
  endtask

  // HALT cycle, optionally with reset asserted for the coming edge.
  task automatic H(input logic n, input logic [7:0] pc, input logic [7:0] imm, input logic trap);
    drv(n, 1'b1, 8'h12, 1'b1);
    push(pc, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b00, 3'd0, imm, 1'b1, trap);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end

  initial begin
    drv(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    // Reset state, stalled fetch
    F(1'b0, 8'h00, 8'h00, 8'h00);
    // ST R2
    F(1'b1, 8'h12, 8'h00, 8'h00);
    E(1'b0, 8'h01, 4'b0100, 1'b1, 1'b0, 2'b00, 3'd0, 8'h00);
    // LDI 0x5A
    F(1'b1, 8'h80, 8'h01, 8'h00);
    F(1'b1, 8'h5A, 8'h02, 8'h00);
    E(1'b0, 8'h03, 4'b0000, 1'b0, 1'b1, 2'b10, 3'd0, 8'h5A);
    // XOR R3 then four stall cycles
    F(1'b1, 8'h73, 8'h03, 8'h5A);
    E(1'b0, 8'h04, 4'b1000, 1'b0, 1'b1, 2'b00, 3'd4, 8'h5A);
    for (int i = 0; i < 4; i++) F(1'b0, 8'h21, 8'h04, 8'h5A);
    // LD R1
    F(1'b1, 8'h21, 8'h04, 8'h5A);
    E(1'b0, 8'h05, 4'b0010, 1'b0, 1'b1, 2'b01, 3'd0, 8'h5A);
    // SUB R0 with IR[3:2] set
    F(1'b1, 8'h4C, 8'h05, 8'h5A);
    E(1'b0, 8'h06, 4'b0001, 1'b0, 1'b1, 2'b00, 3'd1, 8'h5A);
    // AND R1, OR R3, ADD R0
    F(1'b1, 8'h51, 8'h06, 8'h5A);
    E(1'b0, 8'h07, 4'b0010, 1'b0, 1'b1, 2'b00, 3'd2, 8'h5A);
    F(1'b1, 8'h63, 8'h07, 8'h5A);
    E(1'b0, 8'h08, 4'b1000, 1'b0, 1'b1, 2'b00, 3'd3, 8'h5A);
    F(1'b1, 8'h30, 8'h08, 8'h5A);
    E(1'b0, 8'h09, 4'b0001, 1'b0, 1'b1, 2'b00, 3'd0, 8'h5A);
    // JZ 0x10 taken
    F(1'b1, 8'hA0, 8'h09, 8'h5A);
    F(1'b1, 8'h10, 8'h0A, 8'h5A);
    E(1'b1, 8'h0B, 4'b0000, 1'b0, 1'b0, 2'b00, 3'd0, 8'h10);
    // JZ 0x20 not taken
    F(1'b1, 8'hA0, 8'h10, 8'h10);
    F(1'b1, 8'h20, 8'h11, 8'h10);
    E(1'b0, 8'h12, 4'b0000, 1'b0, 1'b0, 2'b00, 3'd0, 8'h20);
    // JMP 0xFF, then NOP fetched at 0xFF wraps PC to 0
    F(1'b1, 8'h90, 8'h12, 8'h20);
    F(1'b1, 8'hFF, 8'h13, 8'h20);
    E(1'b0, 8'h14, 4'b0000, 1'b0, 1'b0, 2'b00, 3'd0, 8'hFF);
    F(1'b1, 8'h00, 8'hFF, 8'hFF);
    E(1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 2'b00, 3'd0, 8'hFF);
    // Reset asserted while waiting in IMM
    F(1'b1, 8'h80, 8'h00, 8'hFF);
    drv(1'b0, 1'b1, 8'h33, 1'b0);
    push(8'h01, 1'b1, 4'b0000, 1'b0, 1'b0, 2'b00, 3'd0, 8'hFF, 1'b0, 1'b0);
    tick();
    F(1'b0, 8'h00, 8'h00, 8'h00);
    // HLT: frozen for 10 cycles, then one reset edge
    F(1'b1, 8'hF0, 8'h00, 8'h00);
    E(1'b0, 8'h01, 4'b0000, 1'b0, 1'b0, 2'b00, 3'd0, 8'h00);
    for (int i = 0; i < 10; i++) H(1'b1, 8'h01, 8'h00, 1'b0);
    H(1'b0, 8'h01, 8'h00, 1'b0);
    F(1'b0, 8'h00, 8'h00, 8'h00);
    // Illegal opcode 0xC0
    F(1'b1, 8'hC0, 8'h00, 8'h00);
    E(1'b0, 8'h01, 4'b0000, 1'b0, 1'b0, 2'b00, 3'd0, 8'h00);
`ifdef IDSEQ_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) H(1'b1, 8'h01, 8'h00, 1'b1);
    H(1'b0, 8'h01, 8'h00, 1'b1);
    F(1'b0, 8'h00, 8'h00, 8'h00);
`else
    F(1'b1, 8'h00, 8'h01, 8'h00);
    E(1'b0, 8'h02, 4'b0000, 1'b0, 1'b0, 2'b00, 3'd0, 8'h00);
    F(1'b0, 8'h00, 8'h02, 8'h00);
`endif
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
